// File: rtl/rv_issue_pkg.sv
// Shared decode definitions for the issue stage: opcode constants, instruction field
// layout and per-opcode register usage classes.
package rv_issue_pkg;

   localparam logic [6:0] OP        = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_32     = 7'b0111011;
   localparam logic [6:0] OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] LOAD      = 7'b0000011;
   localparam logic [6:0] STORE     = 7'b0100011;
   localparam logic [6:0] BRANCH    = 7'b1100011;
   localparam logic [6:0] JAL       = 7'b1101111;
   localparam logic [6:0] JALR      = 7'b1100111;
   localparam logic [6:0] LUI       = 7'b0110111;
   localparam logic [6:0] AUIPC     = 7'b0010111;

   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } instr_fields_t;

   // Returns {uses_rs1, uses_rs2, writes_rd}; unknown opcodes touch no registers.
   function automatic logic [2:0] op_usage(input logic [6:0] opcode);
      case (opcode)
         OP, OP_32:                       op_usage = 3'b111;
         OP_IMM, OP_IMM_32, LOAD, JALR:   op_usage = 3'b101;
         STORE, BRANCH:                   op_usage = 3'b110;
         JAL, LUI, AUIPC:                 op_usage = 3'b001;
         default:                         op_usage = 3'b000;
      endcase
   endfunction

   function automatic logic idx_in_range(input logic [4:0] idx, input int nregs);
      return int'({27'd0, idx}) < nregs;
   endfunction

endpackage

// File: rtl/regfile_array.sv
// NREGS x XLEN register storage: two combinational read ports, one write port.
// x0 and out-of-range indices read as zero; writes to them are dropped.
module regfile_array
   import rv_issue_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [4:0]      rd_addr_a,
   output logic [XLEN-1:0] rd_data_a,
   input  logic [4:0]      rd_addr_b,
   output logic [XLEN-1:0] rd_data_b,
   input  logic            wr_en,
   input  logic [4:0]      wr_addr,
   input  logic [XLEN-1:0] wr_data
);

   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0] mem_q [NREGS];
   logic [XLEN-1:0] mem_d [NREGS];
   logic            wr_ok;

   always_comb begin
      wr_ok = wr_en && (wr_addr != 5'd0) && idx_in_range(wr_addr, NREGS);
      for (int i = 0; i < NREGS; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (wr_ok) begin
         mem_d[wr_addr[AW-1:0]] = wr_data;
      end
      mem_d[0] = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   always_comb begin
      rd_data_a = '0;
      rd_data_b = '0;
      if (rd_addr_a != 5'd0 && idx_in_range(rd_addr_a, NREGS)) begin
         rd_data_a = mem_q[rd_addr_a[AW-1:0]];
      end
      if (rd_addr_b != 5'd0 && idx_in_range(rd_addr_b, NREGS)) begin
         rd_data_b = mem_q[rd_addr_b[AW-1:0]];
      end
   end

endmodule

// File: rtl/regfile_issue_stage.sv
// Decode/register-read issue stage with busy-bit scoreboard and RAW/WAW stall.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data into the operands.
module regfile_issue_stage
   import rv_issue_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instruction,
   input  logic            wb_valid,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [6:0]      out_opcode,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_rs1_data,
   output logic [XLEN-1:0] out_rs2_data,
   output logic            out_illegal
);

   localparam int AW = $clog2(NREGS);

   instr_fields_t   f;
   logic            use_rs1, use_rs2, wr_rd;
   logic            rs1_ok, rs2_ok, rd_ok;
   logic            illegal, wb_ok;
   logic            rs1_busy, rs2_busy, rd_busy;
   logic            src_hazard, waw, hazard, fire;
   logic [XLEN-1:0] rd_data_a, rd_data_b, rs1_val, rs2_val;
`ifdef REGFILE_BYPASS_EN
   logic            rs1_fwd, rs2_fwd;
`endif

   logic [NREGS-1:0] busy_q, busy_d;
   logic             out_valid_q, out_valid_d;
   logic [6:0]       opcode_q, opcode_d, funct7_q, funct7_d;
   logic [2:0]       funct3_q, funct3_d;
   logic [4:0]       rd_q, rd_d;
   logic [XLEN-1:0]  rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
   logic             illegal_q, illegal_d;

   regfile_array #(.XLEN(XLEN), .NREGS(NREGS)) u_array (
      .clk       (clk),
      .reset     (reset),
      .rd_addr_a (f.rs1),
      .rd_data_a (rd_data_a),
      .rd_addr_b (f.rs2),
      .rd_data_b (rd_data_b),
      .wr_en     (wb_valid),
      .wr_addr   (wb_rd),
      .wr_data   (wb_data)
   );

   always_comb begin
      f = instr_fields_t'(instruction);
      {use_rs1, use_rs2, wr_rd} = op_usage(f.opcode);
      rs1_ok   = idx_in_range(f.rs1, NREGS);
      rs2_ok   = idx_in_range(f.rs2, NREGS);
      rd_ok    = idx_in_range(f.rd, NREGS);
      illegal  = (use_rs1 && !rs1_ok) || (use_rs2 && !rs2_ok) || (wr_rd && !rd_ok);
      wb_ok    = wb_valid && (wb_rd != 5'd0) && idx_in_range(wb_rd, NREGS);
      rs1_busy = rs1_ok && busy_q[f.rs1[AW-1:0]];
      rs2_busy = rs2_ok && busy_q[f.rs2[AW-1:0]];
      rd_busy  = rd_ok && busy_q[f.rd[AW-1:0]];
`ifdef REGFILE_BYPASS_EN
      rs1_fwd    = wb_ok && (wb_rd == f.rs1);
      rs2_fwd    = wb_ok && (wb_rd == f.rs2);
      src_hazard = (use_rs1 && rs1_busy && !rs1_fwd) || (use_rs2 && rs2_busy && !rs2_fwd);
      rs1_val    = rs1_fwd ? wb_data : rd_data_a;
      rs2_val    = rs2_fwd ? wb_data : rd_data_b;
`else
      src_hazard = (use_rs1 && rs1_busy) || (use_rs2 && rs2_busy);
      rs1_val    = rd_data_a;
      rs2_val    = rd_data_b;
`endif
      waw      = wr_rd && (f.rd != 5'd0) && rd_busy;
      hazard   = !illegal && (src_hazard || waw);
      in_ready = !hazard && (!out_valid_q || out_ready);
      fire     = in_valid && in_ready;
   end

   // Writeback clear is applied first so a same-index issue re-marks the register busy.
   always_comb begin
      busy_d = busy_q;
      if (wb_ok) begin
         busy_d[wb_rd[AW-1:0]] = 1'b0;
      end
      if (fire && wr_rd && !illegal && (f.rd != 5'd0)) begin
         busy_d[f.rd[AW-1:0]] = 1'b1;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      opcode_d    = opcode_q;
      funct3_d    = funct3_q;
      funct7_d    = funct7_q;
      rd_d        = rd_q;
      rs1_data_d  = rs1_data_q;
      rs2_data_d  = rs2_data_q;
      illegal_d   = illegal_q;
      if (fire) begin
         out_valid_d = 1'b1;
         opcode_d    = f.opcode;
         funct3_d    = f.funct3;
         funct7_d    = f.funct7;
         rd_d        = f.rd;
         rs1_data_d  = use_rs1 ? rs1_val : '0;
         rs2_data_d  = use_rs2 ? rs2_val : '0;
         illegal_d   = illegal;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q      <= '0;
         out_valid_q <= 1'b0;
         opcode_q    <= '0;
         funct3_q    <= '0;
         funct7_q    <= '0;
         rd_q        <= '0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         illegal_q   <= 1'b0;
      end else begin
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         opcode_q    <= opcode_d;
         funct3_q    <= funct3_d;
         funct7_q    <= funct7_d;
         rd_q        <= rd_d;
         rs1_data_q  <= rs1_data_d;
         rs2_data_q  <= rs2_data_d;
         illegal_q   <= illegal_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_opcode   = opcode_q;
   assign out_funct3   = funct3_q;
   assign out_funct7   = funct7_q;
   assign out_rd       = rd_q;
   assign out_rs1_data = rs1_data_q;
   assign out_rs2_data = rs2_data_q;
   assign out_illegal  = illegal_q;

endmodule

// File: tb/tb_regfile_issue_stage.sv
// Bench for regfile_issue_stage: directed scenarios plus a randomized run against a
// behavioural scoreboard model. Honours REGFILE_BYPASS_EN when defined.
module tb_regfile_issue_stage;

   localparam int XLEN = 64;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam logic [6:0] C_OP = 7'h33, C_OPI = 7'h13, C_OP32 = 7'h3B, C_OPI32 = 7'h1B;
   localparam logic [6:0] C_LOAD = 7'h03, C_STORE = 7'h23, C_BR = 7'h63, C_JAL = 7'h6F;
   localparam logic [6:0] C_JALR = 7'h67, C_LUI = 7'h37, C_AUIPC = 7'h17;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic            in_valid, in_ready, wb_valid, out_valid, out_ready, out_illegal;
   logic [31:0]     instruction;
   logic [4:0]      wb_rd, out_rd;
   logic [XLEN-1:0] wb_data, out_rs1_data, out_rs2_data;
   logic [6:0]      out_opcode, out_funct7;
   logic [2:0]      out_funct3;

   logic            in_valid16, in_ready16, wb_valid16, out_valid16, out_ready16, out_illegal16;
   logic [31:0]     instr16;
   logic [4:0]      wb_rd16, out_rd16;
   logic [XLEN-1:0] wb_data16, out_rs1_data16, out_rs2_data16;
   logic [6:0]      out_opcode16, out_funct7_16;
   logic [2:0]      out_funct3_16;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_issue_stage #(.XLEN(XLEN), .NREGS(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
      .out_funct3(out_funct3), .out_funct7(out_funct7), .out_rd(out_rd),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_illegal(out_illegal)
   );

   regfile_issue_stage #(.XLEN(XLEN), .NREGS(16)) dut16 (
      .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
      .instruction(instr16), .wb_valid(wb_valid16), .wb_rd(wb_rd16), .wb_data(wb_data16),
      .out_valid(out_valid16), .out_ready(out_ready16), .out_opcode(out_opcode16),
      .out_funct3(out_funct3_16), .out_funct7(out_funct7_16), .out_rd(out_rd16),
      .out_rs1_data(out_rs1_data16), .out_rs2_data(out_rs2_data16), .out_illegal(out_illegal16)
   );

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0; instruction = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
      in_valid16 = 1'b0; instr16 = '0; wb_valid16 = 1'b0; wb_rd16 = '0; wb_data16 = '0; out_ready16 = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_checks++;
      if ({out_opcode, out_funct3, out_funct7, out_rd, out_rs1_data, out_rs2_data, out_illegal} !== '0) begin
         n_fail++; $display("FAIL reset_fields: got op=%h rd=%0d rs1=%h rs2=%h expected all zero",
                            out_opcode, out_rd, out_rs1_data, out_rs2_data);
      end
      n_checks++;
      if (dut.busy_q !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %h expected 0", dut.busy_q); end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_issue();
      instruction = enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd3, C_OP);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      $display("txn issue add x3,x1,x2: valid=%b rd=%0d rs1=%h rs2=%h", out_valid, out_rd, out_rs1_data, out_rs2_data);
      n_checks++;
      if (out_valid !== 1'b1 || out_rd !== 5'd3 || out_opcode !== C_OP) begin
         n_fail++; $display("FAIL issue_pkt: got valid=%b rd=%0d op=%h expected 1/3/33", out_valid, out_rd, out_opcode);
      end
      n_checks++;
      if (out_rs1_data !== 64'd0 || out_rs2_data !== 64'd0) begin
         n_fail++; $display("FAIL issue_operands: got %h %h expected 0 0", out_rs1_data, out_rs2_data);
      end
      n_checks++;
      if (dut.busy_q[3] !== 1'b1) begin n_fail++; $display("FAIL issue_busy3: got %b expected 1", dut.busy_q[3]); end
   endtask

   task automatic test_wb_read();
      wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 64'h1234;
      tick();
      wb_valid = 1'b0;
      instruction = enc_i(12'd1, 5'd1, 3'd0, 5'd5, C_OPI);
      in_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL wbread_in_ready: got %b expected 1", in_ready); end
      tick();
      in_valid = 1'b0;
      $display("txn issue addi x5,x1,1: rd=%0d rs1=%h rs2=%h", out_rd, out_rs1_data, out_rs2_data);
      n_checks++;
      if (out_rs1_data !== 64'h1234 || out_rs2_data !== 64'd0 || out_rd !== 5'd5) begin
         n_fail++; $display("FAIL wbread_pkt: got rs1=%h rs2=%h rd=%0d expected 1234/0/5", out_rs1_data, out_rs2_data, out_rd);
      end
   endtask

   task automatic test_raw();
      do_reset();
      instruction = enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd3, C_OP);
      in_valid = 1'b1;
      tick();
      instruction = enc_r(7'h20, 5'd3, 5'd3, 3'd0, 5'd4, C_OP);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_checks++;
         if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall%0d: got in_ready=%b expected 0", k, in_ready); end
         tick();
      end
      wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 64'h55;
      @(negedge clk);
      n_checks++;
      if (in_ready !== BYP) begin n_fail++; $display("FAIL raw_wb_cycle: got in_ready=%b expected %b", in_ready, BYP); end
      tick();
      wb_valid = 1'b0;
`ifndef REGFILE_BYPASS_EN
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release: got in_ready=%b expected 1", in_ready); end
      tick();
`endif
      in_valid = 1'b0;
      $display("txn issue sub x4,x3,x3: rd=%0d rs1=%h rs2=%h", out_rd, out_rs1_data, out_rs2_data);
      n_checks++;
      if (out_valid !== 1'b1 || out_rd !== 5'd4 || out_funct7 !== 7'h20 || out_rs1_data !== 64'h55 || out_rs2_data !== 64'h55) begin
         n_fail++; $display("FAIL raw_pkt: got valid=%b rd=%0d f7=%h rs1=%h rs2=%h expected 1/4/20/55/55",
                            out_valid, out_rd, out_funct7, out_rs1_data, out_rs2_data);
      end
      n_checks++;
      if (dut.busy_q !== 32'h10) begin n_fail++; $display("FAIL raw_busy: got %h expected 00000010", dut.busy_q); end
   endtask

   task automatic test_illegal();
      do_reset();
      instr16 = enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd20, C_OP);
      in_valid16 = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_checks++;
         if (in_ready16 !== 1'b1) begin n_fail++; $display("FAIL illegal_no_stall%0d: got %b expected 1", k, in_ready16); end
         tick();
         $display("txn issue16 add x20,x1,x2: illegal=%b rd=%0d", out_illegal16, out_rd16);
         n_checks++;
         if (out_valid16 !== 1'b1 || out_illegal16 !== 1'b1 || out_rd16 !== 5'd20) begin
            n_fail++; $display("FAIL illegal_pkt%0d: got valid=%b illegal=%b rd=%0d expected 1/1/20", k, out_valid16, out_illegal16, out_rd16);
         end
         n_checks++;
         if (dut16.busy_q !== 16'd0) begin n_fail++; $display("FAIL illegal_busy%0d: got %h expected 0", k, dut16.busy_q); end
      end
      in_valid16 = 1'b0;
      wb_valid16 = 1'b1; wb_rd16 = 5'd20; wb_data16 = 64'hDEAD_BEEF;
      tick();
      wb_valid16 = 1'b0;
      instr16 = enc_r(7'd0, 5'd4, 5'd4, 3'd0, 5'd6, C_OP);
      in_valid16 = 1'b1;
      tick();
      in_valid16 = 1'b0;
      n_checks++;
      if (out_illegal16 !== 1'b0 || out_rs1_data16 !== 64'd0 || out_rs2_data16 !== 64'd0) begin
         n_fail++; $display("FAIL illegal_wb_ignored: got illegal=%b rs1=%h rs2=%h expected 0/0/0", out_illegal16, out_rs1_data16, out_rs2_data16);
      end
      n_checks++;
      if (dut16.busy_q !== 16'h0040) begin n_fail++; $display("FAIL illegal_legal_busy: got %h expected 0040", dut16.busy_q); end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      instruction = enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd3, C_OP);
      in_valid = 1'b1;
      tick();
      instruction = enc_i(12'd5, 5'd0, 3'd0, 5'd6, C_OPI);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready%0d: got %b expected 0", k, in_ready); end
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || out_rd !== 5'd3 || out_opcode !== C_OP) begin
            n_fail++; $display("FAIL bp_hold%0d: got valid=%b rd=%0d op=%h expected 1/3/33", k, out_valid, out_rd, out_opcode);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
      tick();
      in_valid = 1'b0;
      $display("txn issue addi x6,x0,5 after release: rd=%0d op=%h", out_rd, out_opcode);
      n_checks++;
      if (out_valid !== 1'b1 || out_rd !== 5'd6 || out_opcode !== C_OPI || out_rs1_data !== 64'd0) begin
         n_fail++; $display("FAIL bp_next_pkt: got valid=%b rd=%0d op=%h rs1=%h expected 1/6/13/0", out_valid, out_rd, out_opcode, out_rs1_data);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got out_valid=%b expected 0", out_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0;
      instruction = enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd7, C_OP);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || dut.busy_q[7] !== 1'b1) begin
         n_fail++; $display("FAIL rmid_setup: got valid=%b busy7=%b expected 1/1", out_valid, dut.busy_q[7]);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || dut.busy_q !== 32'd0) begin
         n_fail++; $display("FAIL rmid_async: got valid=%b busy=%h expected 0/0", out_valid, dut.busy_q);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      out_ready = 1'b1;
      instruction = {20'h00001, 5'd7, C_LUI};
      in_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_lui_ready: got %b expected 1", in_ready); end
      tick();
      in_valid = 1'b0;
      $display("txn issue lui x7,1: rd=%0d f3=%0d op=%h", out_rd, out_funct3, out_opcode);
      n_checks++;
      if (out_valid !== 1'b1 || out_rd !== 5'd7 || out_funct3 !== 3'd1 || out_opcode !== C_LUI || out_rs1_data !== 64'd0) begin
         n_fail++; $display("FAIL rmid_lui_pkt: got valid=%b rd=%0d f3=%0d op=%h rs1=%h expected 1/7/1/37/0",
                            out_valid, out_rd, out_funct3, out_opcode, out_rs1_data);
      end
      wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 64'h99;
      tick();
      wb_valid = 1'b0;
      instruction = enc_i(12'd0, 5'd7, 3'd0, 5'd8, C_OPI);
      in_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_wb_ready: got %b expected 1", in_ready); end
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_rs1_data !== 64'h99) begin n_fail++; $display("FAIL rmid_wb_data: got %h expected 99", out_rs1_data); end
   endtask

   // Scoreboard model state
   logic [XLEN-1:0] m_regs [32];
   logic [31:0]     m_busy;
   logic            m_ov, m_ill;
   logic [6:0]      m_op, m_f7;
   logic [2:0]      m_f3;
   logic [4:0]      m_rd;
   logic [XLEN-1:0] m_r1, m_r2;

   function automatic logic [31:0] rand_instr();
      logic [6:0] ops [11];
      logic [6:0] op;
      ops = '{C_OP, C_OPI, C_OP32, C_OPI32, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC};
      op = ($urandom_range(0, 11) == 11) ? 7'($urandom) : ops[$urandom_range(0, 10)];
      return {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
              5'($urandom_range(0, 7)), op};
   endfunction

   task automatic test_random(input int ncyc);
      logic       last_block, exp_ready, fire, u1, u2, w, haz, byp1, byp2;
      logic [6:0] op;
      logic [4:0] rs1, rs2, rd;
      int         fires;
      do_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_busy = '0; m_ov = 0; m_ill = 0; m_op = '0; m_f7 = '0; m_f3 = '0; m_rd = '0; m_r1 = '0; m_r2 = '0;
      last_block = 1'b0;
      fires = 0;
      for (int c = 0; c < ncyc; c++) begin
         if (!last_block) begin
            in_valid = ($urandom_range(0, 3) != 0);
            instruction = rand_instr();
         end
         wb_valid  = ($urandom_range(0, 4) < 3);
         wb_rd     = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
         wb_data   = {$urandom, $urandom};
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         op  = instruction[6:0];
         rd  = instruction[11:7];
         rs1 = instruction[19:15];
         rs2 = instruction[24:20];
         w   = op inside {C_OP, C_OPI, C_OP32, C_OPI32, C_LOAD, C_JAL, C_JALR, C_LUI, C_AUIPC};
         u2  = op inside {C_OP, C_OP32, C_STORE, C_BR};
         u1  = (w || u2) && !(op inside {C_JAL, C_LUI, C_AUIPC});
         byp1 = BYP && wb_valid && wb_rd == rs1 && rs1 != 0;
         byp2 = BYP && wb_valid && wb_rd == rs2 && rs2 != 0;
         haz = (u1 && m_busy[rs1] && !byp1) || (u2 && m_busy[rs2] && !byp2) || (w && rd != 0 && m_busy[rd]);
         exp_ready = !haz && (!m_ov || out_ready);
         n_checks++;
         if (in_ready !== exp_ready) begin
            n_fail++; $display("FAIL rand_in_ready c=%0d: got %b expected %b (instr=%h)", c, in_ready, exp_ready, instruction);
         end
         fire = in_valid && exp_ready;
         last_block = in_valid && !exp_ready;
         if (fire) begin
            m_ov = 1; m_ill = 0; m_op = op; m_rd = rd; m_f3 = instruction[14:12]; m_f7 = instruction[31:25];
            m_r1 = (!u1 || rs1 == 0) ? '0 : byp1 ? wb_data : m_regs[rs1];
            m_r2 = (!u2 || rs2 == 0) ? '0 : byp2 ? wb_data : m_regs[rs2];
            fires++;
         end else if (out_ready) begin
            m_ov = 0;
         end
         if (wb_valid && wb_rd != 0) begin
            m_regs[wb_rd] = wb_data;
            m_busy[wb_rd] = 1'b0;
         end
         if (fire && w && rd != 0) m_busy[rd] = 1'b1;
         tick();
         if (fire) $display("txn rand %0d: instr=%h rd=%0d rs1=%h rs2=%h", fires, instruction, out_rd, out_rs1_data, out_rs2_data);
         n_checks++;
         if ({out_valid, out_opcode, out_funct3, out_funct7, out_rd, out_rs1_data, out_rs2_data, out_illegal}
             !== {m_ov, m_op, m_f3, m_f7, m_rd, m_r1, m_r2, m_ill}) begin
            n_fail++; $display("FAIL rand_pkt c=%0d: got v=%b op=%h rd=%0d rs1=%h rs2=%h expected v=%b op=%h rd=%0d rs1=%h rs2=%h",
                               c, out_valid, out_opcode, out_rd, out_rs1_data, out_rs2_data, m_ov, m_op, m_rd, m_r1, m_r2);
         end
         n_checks++;
         if (dut.busy_q !== m_busy) begin
            n_fail++; $display("FAIL rand_busy c=%0d: got %h expected %h", c, dut.busy_q, m_busy);
         end
      end
      in_valid = 1'b0;
      wb_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      test_reset();
      test_issue();
      test_wb_read();
      test_raw();
      test_illegal();
      test_backpressure();
      test_reset_mid();
      test_random(600);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_issue_stage.md
# regfile_issue_stage

Parametrised decode/register-read issue stage for the RV64 datapath. Parses a 32-bit instruction, reads both source operands from an internal register file, tracks pending destination writes in a scoreboard, and stalls on RAW/WAW hazards. Issues a registered decoded packet downstream over a valid/ready handshake. Accepts asynchronous writebacks from later pipeline stages.

## Interface
- XLEN, 64, register/data width in bits (32 or 64).
- NREGS, 32, architectural register count (16 for RV-E, or 32); register indices ≥ NREGS are illegal.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction presented.
- in_ready  out  1  stage accepts the instruction this cycle.
- instruction  in  32  RISC-V instruction word.
- wb_valid  in  1  writeback strobe.
- wb_rd  in  5  writeback destination index.
- wb_data  in  XLEN  writeback data.
- out_valid  out  1  decoded packet valid.
- out_ready  in  1  downstream accepts the packet.
- out_opcode  out  7  opcode field (instr[6:0]).
- out_funct3  out  3  funct3 field (instr[14:12]).
- out_funct7  out  7  funct7 field (instr[31:25]).
- out_rd  out  5  rd field (instr[11:7]).
- out_rs1_data  out  XLEN  rs1 operand, or 0 if the instruction does not use rs1.
- out_rs2_data  out  XLEN  rs2 operand, or 0 if the instruction does not use rs2.
- out_illegal  out  1  a used register index is ≥ NREGS.

## Operation
- Usage classes come from the opcode:
  - Writes rd: OP, OP-IMM, OP-32, OP-IMM-32, LOAD, JAL, JALR, LUI, AUIPC.
  - Uses rs2: OP, OP-32, STORE, BRANCH.
  - Uses rs1: all of the above except JAL, LUI, AUIPC.
- x0 always reads 0, is never marked busy, and writes to it are discarded.
- Scoreboard holds one busy bit per register.
- Hazard is set when any of these holds:
  - rs1 is used and busy[rs1];
  - rs2 is used and busy[rs2];
  - rd is written, rd≠0, and busy[rd] (WAW).
- Illegal instructions are never hazards, set no busy bit, and issue with out_illegal=1.
- in_ready = !hazard && (!out_valid || out_ready).
- Fire occurs when in_valid && in_ready. On fire:
  - The output register loads the fields and operands, and out_valid is set.
  - busy[rd] is set if rd is written and rd≠0.
- If out_valid && out_ready and there is no fire, out_valid clears.
- Writeback with wb_valid, wb_rd≠0, wb_rd<NREGS: the array is written and busy[wb_rd] cleared.
- Same-cycle writeback clear and fire set on the same index: the set wins.
- Out-of-range wb_rd is ignored.

## Timing
- Reset values: array all 0, busy all 0, out_valid=0, all out_* data/field outputs 0.
- in_ready is combinational from the current state.
- Issue latency is 1 cycle: the packet appears the cycle after fire.
- Stall release without bypass: the writeback at edge N clears busy, so the dependent instruction fires in cycle N+1 and reads the new value from the array.
- Holding rules: the packet holds stable while out_valid && !out_ready. Upstream must hold instruction while in_valid && !in_ready.
- Reset asserted mid-operation discards the in-flight packet and all busy bits immediately. Writebacks arriving after reset deassertion are still applied.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A busy source whose writeback (wb_valid, matching index) occurs in the same cycle is not a hazard.
  - wb_data is forwarded into the operand, so the dependent instruction fires in the writeback cycle.
  - Same-cycle read of a non-busy register being written also returns wb_data.
- REGFILE_BYPASS_EN undefined: the read returns array contents only, and the stall persists through the writeback cycle.

## Structure
- Shared package rv_issue_pkg holds:
  - opcode localparams (OP, OP_IMM, OP_32, OP_IMM_32, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - a packed struct for the decoded fields;
  - a function returning {uses_rs1, uses_rs2, writes_rd} per opcode.
- One sub-module, regfile_array: NREGS×XLEN storage with two combinational read ports, one write port, x0 forced to zero, and async reset.

## Test plan
- Reset, then issue `add x3,x1,x2` with out_ready=1 → next cycle: out_valid=1, out_rd=3, both operands 0, busy[3]=1.
- wb x1=0x1234, then `addi x5,x1,1` → out_rs1_data=0x1234, out_rs2_data=0, in_ready=1.
- Issue `add x3,..`, then `sub x4,x3,x3` → in_ready=0 until wb x3=0x55.
  - With bypass: fires in the wb cycle, operands 0x55.
  - Without bypass: fires one cycle later.
- NREGS=16, `add x20,x1,x2` → out_illegal=1, busy unchanged, no stall.
- out_ready=0 for 3 cycles with a packet held → packet stable, in_ready=0. On release, a queued instruction fires in the same cycle.
- Reset asserted while out_valid=1 and busy[7]=1 → out_valid=0 and busy clear immediately, and a `lui x7,1` issues the cycle after deassertion.
